// File: rtl/rename_pkg.sv
// Shared types and constants for the register-rename stage: uop/operand
// formats, physical register ids, the renamed packet and the FSM states.
package rename_pkg;

    localparam int NUM_AREGS    = 32;
    localparam int NUM_PREGS    = 64;
    localparam int PREG_W       = $clog2(NUM_PREGS);
    localparam int AREG_W       = $clog2(NUM_AREGS);
    localparam int RN_NUM_PREGS = NUM_PREGS;
    localparam int FREE_CNT_W   = $clog2(NUM_PREGS + 1);

    typedef logic [PREG_W-1:0] t_prf_id;
    typedef logic [AREG_W-1:0] t_areg_id;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_REG  = 2'd1,
        OP_IMM  = 2'd2
    } t_optype;

    typedef struct packed {
        t_optype  optype;
        t_areg_id opreg;
    } t_operand;

    typedef struct packed {
        logic [7:0] opcode;
        t_operand   dst;
        t_operand   src1;
        t_operand   src2;
    } t_uinstr;

    typedef struct packed {
        t_uinstr uinstr;
        t_prf_id psrc1;
        t_prf_id psrc2;
        t_prf_id pdst;
        t_prf_id pdst_old;
    } t_rename_pkt;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } t_rn_state;

    // Pregs below NUM_AREGS back the identity mapping out of reset.
    function automatic logic [NUM_PREGS-1:0] free_reset_vec();
        logic [NUM_PREGS-1:0] v;
        for (int p = 0; p < NUM_PREGS; p++) begin
            v[p] = (p >= NUM_AREGS);
        end
        return v;
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// Free physical register bit vector with a lowest-index allocator, a retire
// free port and a bulk rebuild from the retirement in-use mask on recovery.
module rename_free_list
    import rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_i,
    input  logic                  free_i,
    input  t_prf_id               free_preg_i,
    input  logic                  recover_i,
    input  logic [NUM_PREGS-1:0]  inuse_mask_i,
    output t_prf_id               alloc_preg_o,
    output logic [FREE_CNT_W-1:0] free_cnt_o
);

    logic [NUM_PREGS-1:0] free_q;
    logic [NUM_PREGS-1:0] free_d;

    always_comb begin
        alloc_preg_o = '0;
        free_cnt_o   = '0;
        for (int p = NUM_PREGS - 1; p >= 0; p--) begin
            if (free_q[p]) begin
                alloc_preg_o = t_prf_id'(p);
            end
            free_cnt_o = free_cnt_o + FREE_CNT_W'(free_q[p]);
        end
    end

    always_comb begin
        free_d = free_q;
        if (recover_i) begin
            free_d    = ~inuse_mask_i;
            free_d[0] = 1'b0;
        end else begin
            if (alloc_i) begin
                free_d[alloc_preg_o] = 1'b0;
            end
            if (free_i) begin
                free_d[free_preg_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_q <= free_reset_vec();
        end else begin
            free_q <= free_d;
        end
    end

endmodule

// File: rtl/rename.sv
// Register-rename stage: speculative RAT, retirement RAT, free list and a
// registered output packet. Build with RENAME_PERF_EN to get the stall counter.
module rename
    import rename_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_de1,
    input  t_uinstr     uinstr_de1,
    output logic        rename_ready_rn0,
    input  logic        alloc_ready_rn1,
    input  logic        br_mispred_rb1,
    input  logic        retire_valid_rb1,
    input  t_areg_id    retire_areg_rb1,
    input  t_prf_id     retire_preg_rb1,
    input  t_prf_id     retire_pold_rb1,
    output logic        valid_rn1,
    output t_rename_pkt rpkt_rn1,
    output logic [31:0] perf_stall_cnt
);

    t_rn_state            state_q;
    logic                 valid_q;
    t_rename_pkt          rpkt_q;
    t_rename_pkt          pkt_d;
    t_prf_id              rat_q  [NUM_AREGS];
    t_prf_id              rrat_q [NUM_AREGS];
    t_prf_id              rrat_d [NUM_AREGS];
    logic [NUM_PREGS-1:0] inuse_mask;
    t_prf_id              alloc_preg;
    logic [FREE_CNT_W-1:0] free_cnt;
    logic                 accept;
    logic                 do_alloc;

    assign rename_ready_rn0 = (state_q == ST_RUN) && !br_mispred_rb1 && (free_cnt != '0)
                              && (!valid_q || alloc_ready_rn1);
    assign accept   = valid_de1 && rename_ready_rn0;
    // Areg 0 is hardwired to preg 0, so a write to it allocates nothing.
    assign do_alloc = accept && (uinstr_de1.dst.optype == OP_REG) && (uinstr_de1.dst.opreg != '0);

    assign valid_rn1 = valid_q;
    assign rpkt_rn1  = rpkt_q;

    always_comb begin
        pkt_d        = '0;
        pkt_d.uinstr = uinstr_de1;
        if (uinstr_de1.src1.optype == OP_REG) pkt_d.psrc1 = rat_q[uinstr_de1.src1.opreg];
        if (uinstr_de1.src2.optype == OP_REG) pkt_d.psrc2 = rat_q[uinstr_de1.src2.opreg];
        if (do_alloc) begin
            pkt_d.pdst     = alloc_preg;
            pkt_d.pdst_old = rat_q[uinstr_de1.dst.opreg];
        end
    end

    // The recovery image includes a retire landing in the mispredict cycle.
    always_comb begin
        rrat_d     = rrat_q;
        inuse_mask = '0;
        if (retire_valid_rb1 && (retire_areg_rb1 != '0)) begin
            rrat_d[retire_areg_rb1] = retire_preg_rb1;
        end
        for (int a = 0; a < NUM_AREGS; a++) begin
            inuse_mask[rrat_d[a]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            rpkt_q  <= '0;
        end else if (br_mispred_rb1) begin
            state_q <= ST_RECOVER;
            valid_q <= 1'b0;
            rpkt_q  <= '0;
        end else begin
            state_q <= ST_RUN;
            if (accept) begin
                valid_q <= 1'b1;
                rpkt_q  <= pkt_d;
            end else if (alloc_ready_rn1) begin
                valid_q <= 1'b0;
                rpkt_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < NUM_AREGS; a++) begin
                rat_q[a]  <= t_prf_id'(a);
                rrat_q[a] <= t_prf_id'(a);
            end
        end else begin
            for (int a = 0; a < NUM_AREGS; a++) begin
                rrat_q[a] <= rrat_d[a];
            end
            if (br_mispred_rb1) begin
                for (int a = 0; a < NUM_AREGS; a++) begin
                    rat_q[a] <= rrat_d[a];
                end
            end else if (do_alloc) begin
                rat_q[uinstr_de1.dst.opreg] <= alloc_preg;
            end
        end
    end

    rename_free_list u_free_list (
        .clk          (clk),
        .reset        (reset),
        .alloc_i      (do_alloc),
        .free_i       (retire_valid_rb1 && (retire_pold_rb1 != '0)),
        .free_preg_i  (retire_pold_rb1),
        .recover_i    (br_mispred_rb1),
        .inuse_mask_i (inuse_mask),
        .alloc_preg_o (alloc_preg),
        .free_cnt_o   (free_cnt)
    );

`ifdef RENAME_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if ((state_q == ST_RUN) && !br_mispred_rb1 && !rename_ready_rn0
                     && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/rename.md
Name: rename

Overview:
- Register-rename stage directly downstream of decode.
- Consumes one decoded uop per cycle (valid_de1 / uinstr_de1) and drives rename_ready_rn0 back to decode as the pop enable.
- Maps architectural sources and destinations to physical registers using a speculative RAT, a retirement RAT (RRAT) and a free-physical-register bit vector.
- Emits one registered renamed packet per cycle toward allocation/ROB, and recovers from branch mispredicts by restoring the speculative RAT from the RRAT.

Parameters:
- NUM_AREGS, 32, architectural registers. Areg 0 is hardwired to preg 0.
- NUM_PREGS, 64, physical registers. Must be greater than NUM_AREGS. Preg 0 is never allocated.
- PREG_W, $clog2(NUM_PREGS), physical register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- valid_de1  in  1  uop offered by decode. Asserted only when rename_ready_rn0 was high that cycle.
- uinstr_de1  in  t_uinstr  decoded uop
- rename_ready_rn0  out  1  rename can accept a uop this cycle
- alloc_ready_rn1  in  1  downstream accepts the output this cycle
- br_mispred_rb1  in  1  flush all speculative state
- retire_valid_rb1  in  1  one uop with a register destination retires
- retire_areg_rb1  in  5  retired architectural destination
- retire_preg_rb1  in  PREG_W  retired physical destination
- retire_pold_rb1  in  PREG_W  previous mapping of that areg, to be freed
- valid_rn1  out  1  renamed packet valid
- rpkt_rn1  out  t_rename_pkt  uop plus psrc1, psrc2, pdst, pdst_old
- perf_stall_cnt  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset state:
  - RAT[i] = i and RRAT[i] = i for all i.
  - free[p] = 1 for p in [NUM_AREGS, NUM_PREGS-1], 0 otherwise.
  - valid_rn1 = 0, rpkt_rn1 = '0, perf_stall_cnt = 0, state = RUN.
- States RUN and RECOVER.
  - RUN -> RECOVER when br_mispred_rb1 = 1.
  - RECOVER -> RUN unconditionally after exactly 1 cycle.
- rename_ready_rn0 = (state == RUN) & ~br_mispred_rb1 & (|free) & (~valid_rn1 | alloc_ready_rn1).
- Rename, on accept (valid_de1 = 1):
  - psrcN = RAT[srcN.opreg] when optype == OP_REG; otherwise 0.
  - If dst.optype == OP_REG:
    - pdst = lowest-index set bit of free; clear that bit.
    - pdst_old = RAT[dst.opreg]; then RAT[dst.opreg] = pdst.
  - Otherwise pdst = pdst_old = 0 and no allocation.
- Output register: valid_rn1 / rpkt_rn1 load one cycle after accept.
  - They hold stable while valid_rn1 & ~alloc_ready_rn1.
  - They clear when consumed with no new accept.
- Retire (retire_valid_rb1 = 1):
  - RRAT[retire_areg] = retire_preg.
  - free[retire_pold] = 1 unless retire_pold == 0.
- Free vector, same-cycle allocate and retire-free: both are applied; they never collide on the same preg.
- Mispredict (br_mispred_rb1 = 1):
  - The same-cycle accept is blocked and valid_rn1 is cleared next cycle.
  - On the next edge: RAT = RRAT, with the same-cycle retire update included; free[p] = 1 exactly for pregs not referenced by that updated RRAT, excluding p = 0.
  - RECOVER holds ready low for 1 cycle; the first accept is possible 2 cycles after the mispred.
- Mispred during RECOVER: re-enters RECOVER and repeats the restore.
- Free vector empty: ready = 0, even for uops with no destination (keeps the rule simple).
- Reset asserted mid-operation: all state returns to reset values asynchronously.

Optional Feature:
- Macro RENAME_PERF_EN.
- Defined: perf_stall_cnt increments, saturating at 2^32-1, on each cycle with state == RUN, ~br_mispred_rb1 and ~rename_ready_rn0. Clears on reset.
- Undefined: perf_stall_cnt is tied to 0 and no counter flops exist.

Decomposition:
- common.pkg gets:
  - t_prf_id (PREG_W bits)
  - t_rename_pkt struct { t_uinstr uinstr; t_prf_id psrc1, psrc2, pdst, pdst_old; }
  - constant RN_NUM_PREGS
- Sub-module rename_free_list:
  - Owns the free bit vector and the lowest-set-bit allocator, with a free-count output.
  - Inputs: alloc, free, and recover with an RRAT-derived in-use mask.

Test Plan:
- Reset, then ADD x5,x1,x2 accepted: next cycle psrc1 = 1, psrc2 = 2, pdst = 32, pdst_old = 5, valid_rn1 = 1.
- Back-to-back ADD x5 then SUB x6,x5,x5: second packet has psrc1 = psrc2 = 32, pdst = 33.
- 32 dst-writing uops with no retire: 33rd cycle shows rename_ready_rn0 = 0. Then retire areg 5, preg 32, pold 5: the next uop gets pdst = 5.
- alloc_ready_rn1 held 0 for 3 cycles with valid_rn1 = 1: rpkt_rn1 is unchanged and rename_ready_rn0 = 0. Release: the packet pops and ready returns high.
- Rename x7 -> 32, then br_mispred_rb1 with a same-cycle retire of (7, 40, 7): after recovery RAT[7] = 40, free[32] = 1, free[7] = 1, free[40] = 0, and ready rises 2 cycles after the mispred.
- With RENAME_PERF_EN defined, exhaust the free list for 10 cycles: perf_stall_cnt = 10. With it undefined, perf_stall_cnt stays 0.
